// File: rtl/uart_rx.sv
// UART receiver: synchronises RXD, finds the start edge, takes a 3-sample
// majority vote at mid-bit, deserialises LSB-first and checks the stop bits.
// A good frame updates DOUT with a one-cycle VLD; a bad stop bit gives a
// one-cycle FERR and leaves DOUT alone.
module uart_rx #(
   parameter int Bauds = 115200,
   parameter int Wdata = 8,
   parameter int Wstop = 1,
   parameter int Fclk  = 12000000
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             RXD,
   output logic [Wdata-1:0] DOUT,
   output logic             VLD,
   output logic             FERR,
   output logic             BUSY
);

   localparam int Nticks = Fclk / Bauds;
   localparam int Nhalf  = Nticks / 2;
   localparam int CntW   = $clog2(Nticks);
   localparam int IdxW   = $clog2(Wdata + Wstop + 1);

   typedef enum logic [1:0] {
      IDLE,
      START,
      DATA,
      STOP
   } state_t;

   state_t            state;
   logic [CntW-1:0]   cnt;
   logic [IdxW-1:0]   idx;
   logic [Wdata-1:0]  shreg;
   logic              stop_ok;
   logic              done;

   logic              s1;
   logic              s2;
   logic              h1;
   logic              h2;
   logic              m;
   logic              start_edge;

   // Two-flop synchroniser followed by a short history of the synchronised
   // line; everything resets to the idle-high level so reset never fakes an edge.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         s1 <= 1'b1;
         s2 <= 1'b1;
         h1 <= 1'b1;
         h2 <= 1'b1;
      end else begin
         s1 <= RXD;
         s2 <= s1;
         h1 <= s2;
         h2 <= h1;
      end
   end

   // Majority of the three most recent samples, and a falling edge that needs
   // a 1 seen just before it so a held-low line cannot start a frame.
   assign m          = (s2 & h1) | (s2 & h2) | (h1 & h2);
   assign start_edge = ~s2 & h1;

   // Receive state machine with registered outputs; the frame result is
   // presented one cycle after the final stop sample, by which time the FSM
   // is already back in IDLE and watching for the next start edge.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state   <= IDLE;
         cnt     <= '0;
         idx     <= '0;
         shreg   <= '0;
         stop_ok <= 1'b1;
         done    <= 1'b0;
         DOUT    <= '0;
         VLD     <= 1'b0;
         FERR    <= 1'b0;
         BUSY    <= 1'b0;
      end else begin
         VLD  <= 1'b0;
         FERR <= 1'b0;
         done <= 1'b0;
         BUSY <= (state != IDLE);

         if (done) begin
            if (stop_ok) begin
               DOUT <= shreg;
               VLD  <= 1'b1;
            end else begin
               FERR <= 1'b1;
            end
         end

         case (state)
            IDLE: begin
               if (start_edge) begin
                  state <= START;
                  cnt   <= CntW'(Nhalf - 1);
               end
            end

            START: begin
               if (cnt == '0) begin
                  if (!m) begin
                     state <= DATA;
                     cnt   <= CntW'(Nticks - 1);
                     idx   <= '0;
                  end else begin
                     state <= IDLE;
                  end
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end

            DATA: begin
               if (cnt == '0) begin
                  shreg <= {m, shreg[Wdata-1:1]};
                  cnt   <= CntW'(Nticks - 1);
                  if (idx == IdxW'(Wdata - 1)) begin
                     state   <= STOP;
                     idx     <= '0;
                     stop_ok <= 1'b1;
                  end else begin
                     idx <= idx + 1'b1;
                  end
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end

            STOP: begin
               if (cnt == '0) begin
                  stop_ok <= stop_ok & m;
                  cnt     <= CntW'(Nticks - 1);
                  if (idx == IdxW'(Wstop - 1)) begin
                     state <= IDLE;
                     done  <= 1'b1;
                     idx   <= '0;
                  end else begin
                     idx <= idx + 1'b1;
                  end
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end

            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx at 16 clocks per bit. A behavioural
// serialiser drives RXD and pushes the expected outcome of each frame onto a
// scoreboard; a negedge monitor pops and compares whenever VLD or FERR fires.
module tb_uart_rx;

   logic       CLK;
   logic       RST;
   logic       RXD;
   logic [7:0] DOUT;
   logic       VLD;
   logic       FERR;
   logic       BUSY;

   typedef struct {
      logic       isErr;
      logic [7:0] dout;
      int         cyc;
   } expect_t;

   expect_t    sb[$];
   int         cyc = 0;
   int         totalChecks = 0;
   int         badChecks = 0;
   int         goodSent = 0;
   int         vldSeen = 0;
   logic [7:0] modelDout = 8'h00;
   bit         busyLog [0:99999];

   uart_rx #(
      .Bauds(100000),
      .Wdata(8),
      .Wstop(1),
      .Fclk (1600000)
   ) dut (
      .CLK (CLK),
      .RST (RST),
      .RXD (RXD),
      .DOUT(DOUT),
      .VLD (VLD),
      .FERR(FERR),
      .BUSY(BUSY)
   );

   // 10 ns clock and a running edge counter used to timestamp events
   initial CLK = 1'b0;
   always #5 CLK = ~CLK;
   always @(posedge CLK) cyc++;

   // Single comparison point: counts every check and reports mismatches
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      totalChecks++;
      if (observed !== expected) begin
         badChecks++;
         $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", tag, observed, expected, cyc);
      end
   endtask

   // Hold RXD at one level for one full bit period
   task automatic driveBit(input logic v);
      RXD = v;
      repeat (16) @(posedge CLK);
      #1;
   endtask

   // Serialise one frame and record its expected outcome; the start bit is
   // driven just after edge n, so the result should appear after edge n+156
   task automatic applyStimulus(input logic [7:0] data, input logic stopBit,
                                input int glitchBit, output int startCyc);
      expect_t e;
      startCyc = cyc;
      e.isErr  = ~stopBit;
      if (stopBit) begin
         modelDout = data;
         goodSent++;
      end
      e.dout = modelDout;
      e.cyc  = startCyc + 156;
      sb.push_back(e);
      driveBit(1'b0);
      for (int i = 0; i < 8; i++) begin
         if (i == glitchBit) begin
            RXD = data[i];
            repeat (8) @(posedge CLK);
            #1;
            RXD = ~data[i];
            @(posedge CLK);
            #1;
            RXD = data[i];
            repeat (7) @(posedge CLK);
            #1;
         end else begin
            driveBit(data[i]);
         end
      end
      driveBit(stopBit);
   endtask

   task automatic idleLine(input int n);
      RXD = 1'b1;
      repeat (n) @(posedge CLK);
      #1;
   endtask

   // Scoreboard monitor, sampling on the falling edge
   always @(negedge CLK) begin
      if (cyc < 100000) busyLog[cyc] = BUSY;
      if (RST && (VLD || FERR)) begin
         checkOutput("vld_ferr_both", {31'd0, VLD & FERR}, 32'd0);
         if (VLD) vldSeen++;
         if (sb.size() == 0) begin
            checkOutput("unexpected_out", {31'd0, VLD | FERR}, 32'd0);
         end else begin
            expect_t e;
            e = sb.pop_front();
            checkOutput("kind_ferr", {31'd0, FERR}, {31'd0, e.isErr});
            checkOutput("dout", {24'd0, DOUT}, {24'd0, e.dout});
            checkOutput("out_cycle", cyc, e.cyc);
         end
      end
   end

   initial begin
      int n;
      int anyBusy;
      int waitCyc;

      RXD = 1'b1;
      RST = 1'b0;
      repeat (3) @(posedge CLK);
      @(negedge CLK);
      checkOutput("rst_dout", {24'd0, DOUT}, 32'd0);
      checkOutput("rst_vld", {31'd0, VLD}, 32'd0);
      checkOutput("rst_ferr", {31'd0, FERR}, 32'd0);
      checkOutput("rst_busy", {31'd0, BUSY}, 32'd0);
      @(posedge CLK);
      #1;
      RST = 1'b1;
      idleLine(20);

      $display("[TB] single frame 0xA5");
      applyStimulus(8'hA5, 1'b1, -1, n);
      checkOutput("busy_pre", {31'd0, busyLog[n+3]}, 32'd0);
      checkOutput("busy_rise", {31'd0, busyLog[n+4]}, 32'd1);
      checkOutput("busy_last", {31'd0, busyLog[n+155]}, 32'd1);
      checkOutput("busy_fall", {31'd0, busyLog[n+156]}, 32'd0);
      idleLine(20);

      $display("[TB] back-to-back 0x00, 0xFF");
      applyStimulus(8'h00, 1'b1, -1, n);
      applyStimulus(8'hFF, 1'b1, -1, n);
      idleLine(20);

      $display("[TB] bad stop bit then break");
      applyStimulus(8'h3C, 1'b0, -1, n);
      RXD = 1'b0;
      repeat (200) @(posedge CLK);
      #1;
      anyBusy = 0;
      for (int i = n + 156; i < n + 360; i++) anyBusy |= int'(busyLog[i]);
      checkOutput("break_busy", anyBusy, 32'd0);
      idleLine(40);
      applyStimulus(8'h11, 1'b1, -1, n);
      idleLine(20);

      $display("[TB] short low pulse and glitched frame");
      n = cyc;
      RXD = 1'b0;
      repeat (3) @(posedge CLK);
      #1;
      RXD = 1'b1;
      repeat (30) @(posedge CLK);
      #1;
      checkOutput("glitch_busy_pre", {31'd0, busyLog[n+3]}, 32'd0);
      checkOutput("glitch_busy_rise", {31'd0, busyLog[n+4]}, 32'd1);
      checkOutput("glitch_busy_last", {31'd0, busyLog[n+11]}, 32'd1);
      checkOutput("glitch_busy_fall", {31'd0, busyLog[n+12]}, 32'd0);
      applyStimulus(8'hFF, 1'b1, 3, n);
      idleLine(20);

      $display("[TB] reset in the middle of a frame");
      RXD = 1'b0;
      driveBit(1'b0);
      for (int i = 0; i < 4; i++) driveBit(i[0]);
      RXD = 1'b0;
      repeat (8) @(posedge CLK);
      checkOutput("busy_mid_frame", {31'd0, BUSY}, 32'd1);
      #3;
      RST = 1'b0;
      #1;
      checkOutput("arst_dout", {24'd0, DOUT}, 32'd0);
      checkOutput("arst_vld", {31'd0, VLD}, 32'd0);
      checkOutput("arst_ferr", {31'd0, FERR}, 32'd0);
      checkOutput("arst_busy", {31'd0, BUSY}, 32'd0);
      RXD = 1'b1;
      modelDout = 8'h00;
      repeat (4) @(posedge CLK);
      #1;
      RST = 1'b1;
      idleLine(40);
      applyStimulus(8'h5A, 1'b1, -1, n);
      idleLine(20);

      $display("[TB] 256 back-to-back words");
      for (int w = 0; w < 256; w++) applyStimulus(8'(w), 1'b1, -1, n);
      idleLine(20);

      waitCyc = 0;
      while (sb.size() != 0 && waitCyc < 400) begin
         @(posedge CLK);
         waitCyc++;
      end
      checkOutput("sb_empty", sb.size(), 32'd0);
      checkOutput("vld_count", vldSeen, goodSent);

      $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
      $finish;
   end

endmodule
